// File: rtl/sum_accum.sv
// sum_accum: accumulates NUM_TERMS consecutive sums from the upstream
// carry-select adder into a guard-bit widened accumulator and presents the
// completed total on acc_out under a valid/ready handshake. The upstream adder
// cannot stall, so sums that arrive while a result is still waiting for the
// consumer are dropped and flagged on the sticky overrun output.
//
// Optional feature: define SUM_ACCUM_OVR_CNT_EN to add the 8-bit saturating
// ovr_count output, which counts dropped sums.
module sum_accum #(
  parameter int BLOCK_SIZE = 14,
  parameter int NUM_BLOCKS = 4,
  parameter int NUM_TERMS  = 16,
  parameter int GUARD_BITS = 4,
  localparam int DAT_WIDTH = BLOCK_SIZE * NUM_BLOCKS,
  localparam int ACC_WIDTH = DAT_WIDTH + 1 + GUARD_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAT_WIDTH:0]    sum_in,
  input  logic                  sum_valid,
  input  logic                  clear,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  acc_valid,
  input  logic                  acc_ready,
  output logic [GUARD_BITS:0]   acc_count,
  output logic                  overrun
`ifdef SUM_ACCUM_OVR_CNT_EN
  ,
  output logic [7:0]            ovr_count
`endif
);

  typedef enum logic {
    ACC  = 1'b0,  // absorbing sums into the partial accumulation
    FULL = 1'b1   // completed result presented, waiting for acc_ready
  } state_t;

  // acc_count value at which the next absorbed sum completes the result.
  localparam logic [GUARD_BITS:0] LAST_CNT = (GUARD_BITS + 1)'(NUM_TERMS - 1);
  localparam logic [GUARD_BITS:0] ONE_CNT  = (GUARD_BITS + 1)'(1);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum_ext;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 accept;

  // Sums are unsigned; the guard bits absorb the growth of NUM_TERMS terms.
  assign sum_ext  = {{GUARD_BITS{1'b0}}, sum_in};
  assign acc_next = acc + sum_ext;

  // A sum is taken while accumulating, or in FULL when the consumer empties
  // the output slot in the same cycle. acc and acc_count are already zero in
  // FULL, so a restart simply absorbs the new sum on top of zero.
  assign accept = sum_valid && ((state == ACC) || acc_ready);

  // acc_valid is a direct decode of the state flop, so it is glitch-free.
  assign acc_valid = (state == FULL);

  // Single sequential process: rst beats clear, clear beats all data inputs.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation that disagrees with the synthesized netlist.
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      acc_out   <= '0;
      acc_count <= '0;
      overrun   <= 1'b0;
`ifdef SUM_ACCUM_OVR_CNT_EN
      ovr_count <= 8'd0;
`endif
    end else if (clear) begin
      // Flush partial and pending results; a coincident sum is discarded.
      state     <= ACC;
      acc       <= '0;
      acc_out   <= '0;
      acc_count <= '0;
      overrun   <= 1'b0;
`ifdef SUM_ACCUM_OVR_CNT_EN
      ovr_count <= 8'd0;
`endif
    end else if (accept) begin
      if (acc_count == LAST_CNT) begin
        // Last term: publish the total and re-arm the accumulator.
        state     <= FULL;
        acc_out   <= acc_next;
        acc       <= '0;
        acc_count <= '0;
      end else begin
        state     <= ACC;
        acc       <= acc_next;
        acc_count <= acc_count + ONE_CNT;
      end
    end else if (state == FULL) begin
      if (acc_ready) begin
        // Handshake without a new sum: back to an empty accumulation.
        state <= ACC;
      end else if (sum_valid) begin
        // Output slot still occupied and upstream cannot stall: drop it.
        overrun <= 1'b1;
`ifdef SUM_ACCUM_OVR_CNT_EN
        if (ovr_count != 8'hFF) begin
          ovr_count <= ovr_count + 8'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// Self-checking bench for sum_accum with NUM_TERMS=4. Completed results are
// pushed to a scoreboard queue when the last term is driven and popped when
// acc_valid rises; handshake, count and overrun state follow a small
// behavioural model of the accumulator protocol.
module tb_sum_accum;

  localparam int NT   = 4;
  localparam int DW   = 56;
  localparam int AW   = 61;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW:0]   sum_in = '0;
  logic          sum_valid = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready = 1'b0;
  logic [4:0]    acc_count;
  logic          overrun;
`ifdef SUM_ACCUM_OVR_CNT_EN
  logic [7:0]    ovr_count;
`endif

  sum_accum #(.NUM_TERMS(NT)) dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .sum_valid (sum_valid),
    .clear     (clear),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_count (acc_count),
    .overrun   (overrun)
`ifdef SUM_ACCUM_OVR_CNT_EN
    ,
    .ovr_count (ovr_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model and scoreboard.
  bit            m_full = 1'b0;
  logic [AW-1:0] m_sum = '0;
  int            m_cnt = 0;
  bit            m_ovr_flag = 1'b0;
  int            m_ovr = 0;
  logic [AW-1:0] last_res = '0;
  logic [AW-1:0] exp_q[$];
  bit            prev_v = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_sum = '0; m_cnt = 0;
    m_ovr_flag = 1'b0; m_ovr = 0; last_res = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic valid, input logic [DW:0] v, input logic rdy);
    if (valid && (!m_full || rdy)) begin
      m_full = 1'b0;
      m_sum  = m_sum + AW'(v);
      m_cnt++;
      if (m_cnt == NT) begin
        exp_q.push_back(m_sum);
        last_res = m_sum;
        m_full = 1'b1;
        m_sum = '0;
        m_cnt = 0;
      end
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end else if (m_full && valid) begin
      m_ovr_flag = 1'b1;
      if (m_ovr < 255) m_ovr++;
    end
  endtask

  // One clock: drive at the falling edge, return 1 time unit after rising.
  task automatic cycle(input logic valid, input logic [DW:0] v, input logic rdy);
    @(negedge clk);
    sum_valid = valid;
    sum_in    = v;
    acc_ready = rdy;
    model_step(valid, v, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1; sum_valid = 1'b0; acc_ready = rdy; clear = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_clear_with_sum(input logic [DW:0] v);
    @(negedge clk);
    clear = 1'b1; sum_valid = 1'b1; sum_in = v; acc_ready = 1'b0;
    m_full = 1'b0; m_sum = '0; m_cnt = 0; m_ovr_flag = 1'b0; m_ovr = 0;
    last_res = '0; exp_q.delete();
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"},   64'(acc_valid), 64'(m_full));
    check({tag, "_count"},   64'(acc_count), 64'(m_cnt));
    check({tag, "_overrun"}, 64'(overrun),   64'(m_ovr_flag));
    if (m_full) check({tag, "_out"}, 64'(acc_out), 64'(last_res));
`ifdef SUM_ACCUM_OVR_CNT_EN
    check({tag, "_ovr_count"}, 64'(ovr_count), 64'(m_ovr));
`endif
  endtask

  // Scoreboard monitor: each rising acc_valid must match the oldest result.
  always @(posedge clk) begin
    #1;
    if (acc_valid === 1'b1 && !prev_v) begin
      if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
      else                   check("result", 64'(acc_out), 64'(exp_q.pop_front()));
    end
    prev_v = (acc_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW:0] big;
    big = '1;

    // Reset state.
    do_reset(1'b0);
    do_reset(1'b0);
    check("rst_out", 64'(acc_out), 64'd0);
    check_state("rst");

    // 1+2+3+4 with no consumer: result appears, then holds.
    for (int i = 1; i <= 4; i++) cycle(1'b1, (DW+1)'(i), 1'b0);
    check("sum_10", 64'(acc_out), 64'd10);
    check_state("full");
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    check("hold_out", 64'(acc_out), 64'd10);
    check_state("hold");

    // Handshake with a simultaneous sum: no loss, count restarts at 1.
    cycle(1'b1, (DW+1)'(7), 1'b1);
    check_state("restart");
    check("restart_cnt", 64'(acc_count), 64'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, '0, 1'b0);
    check("sum_7", 64'(acc_out), 64'd7);

    // Two sums while FULL and not ready: dropped, overrun set.
    cycle(1'b1, (DW+1)'(5), 1'b0);
    cycle(1'b1, (DW+1)'(6), 1'b0);
    check("drop_out", 64'(acc_out), 64'd7);
    check("drop_overrun", 64'(overrun), 64'd1);
`ifdef SUM_ACCUM_OVR_CNT_EN
    check("drop_ovr_count", 64'(ovr_count), 64'd2);
`endif
    check_state("drop");
    cycle(1'b0, '0, 1'b1);
    check_state("drain");

    // Maximum operands: no truncation in 61 bits.
    for (int i = 0; i < 4; i++) cycle(1'b1, big, 1'b0);
    check("big_sum", 64'(acc_out), 64'h07FF_FFFF_FFFF_FFFC);
    check_state("big");
    cycle(1'b0, '0, 1'b1);

    // clear with a coincident sum after two terms.
    cycle(1'b1, (DW+1)'(1), 1'b0);
    cycle(1'b1, (DW+1)'(1), 1'b0);
    do_clear_with_sum((DW+1)'(9));
    check("clear_count", 64'(acc_count), 64'd0);
    check("clear_overrun", 64'(overrun), 64'd0);
    check_state("clear");
    for (int i = 0; i < 4; i++) cycle(1'b1, (DW+1)'(1), 1'b0);
    check("sum_4", 64'(acc_out), 64'd4);

    // Reset while FULL with acc_ready high: nothing completes, all zero.
    do_reset(1'b1);
    check("rstfull_out", 64'(acc_out), 64'd0);
    check_state("rstfull");

    // Random traffic with random back-pressure.
    for (int i = 0; i < 80; i++) begin
      cycle(1'($urandom_range(0, 1)), (DW+1)'({$urandom, $urandom}),
            1'($urandom_range(0, 1)));
      check_state("rand");
    end
    cycle(1'b0, '0, 1'b1);
    check_state("rand_drain");

`ifdef SUM_ACCUM_OVR_CNT_EN
    // Dropped-sum counter saturates at 255.
    for (int i = 0; i < 4; i++) cycle(1'b1, (DW+1)'(3), 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b1, (DW+1)'(1), 1'b0);
    check("ovr_sat", 64'(ovr_count), 64'd255);
    check_state("sat");
    cycle(1'b0, '0, 1'b1);
`endif

    cycle(1'b0, '0, 1'b0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
